// File: rtl/smpc_pad_scan.sv
// smpc_pad_scan -- sequential peripheral pad scanner.
//
// Walks NPORTS peripheral ports. For each enabled port it drives the
// TH/TR select pair (PO bits 6:5) through four phases, waits SETTLE CE
// ticks per phase, and samples the returned nibble on PI bits 3:0. The
// four nibbles form a 4-byte record per port in a small result buffer
// that can be read at any time.
//
// Ports
//   CLK      system clock, rising edge
//   RST      synchronous active-high reset
//   CE       clock enable for FSM, counters and buffer writes
//   START    one-CLK scan request, accepted only while idle
//   PORT_EN  per-port enable
//   PI       port input pins, port n at [7n+6:7n]
//   PO       port output pins, port n at [7n+6:7n] (bit6=TH, bit5=TR)
//   BUSY     scan in progress
//   DONE     one-CLK pulse when the scan completes
//   RD_ADDR  result-buffer byte address. It is one bit wider than the
//            buffer needs when 4*NPORTS is a power of two, so that
//            out-of-range addresses (which read 8'hFF) can be expressed.
//   RD_DATA  registered read data, valid one CLK after RD_ADDR
//
// state  | meaning
// -------+---------------------------------------------------------
// IDLE   | waiting for a pending START
// PORT   | choose scan or disconnected record for current port
// DRIVE  | drive select phase onto PO, load settle timer
// WAIT   | settle timer counts down to 1
// SAMPLE | capture nibble; next phase, or write record and advance
// FIN    | pulse DONE, drop BUSY

module smpc_pad_scan #(
   parameter  int NPORTS = 2,
   parameter  int SETTLE = 16,
   localparam int AW     = $clog2(4*NPORTS+1)
) (
   input  logic                  CLK,
   input  logic                  RST,
   input  logic                  CE,
   input  logic                  START,
   input  logic [NPORTS-1:0]     PORT_EN,
   input  logic [7*NPORTS-1:0]   PI,
   output logic [7*NPORTS-1:0]   PO,
   output logic                  BUSY,
   output logic                  DONE,
   input  logic [AW-1:0]         RD_ADDR,
   output logic [7:0]            RD_DATA
);

   localparam int         NB      = 4*NPORTS;
   localparam int         IW      = (NPORTS > 1) ? $clog2(NPORTS) : 1;
   localparam int         CW      = $clog2(SETTLE+1);
   localparam logic [6:0] PO_IDLE = 7'b1100000;

   typedef enum logic [2:0] {
      S_IDLE, S_PORT, S_DRIVE, S_WAIT, S_SAMPLE, S_FIN
   } state_t;

   state_t              state;
   logic                pending;
   logic [IW-1:0]       idx;
   logic [1:0]          phase;
   logic [CW-1:0]       cnt;
   logic [3:0]          nib0, nib1, nib2;
   logic [7*NPORTS-1:0] pi_m, pi_s, po_r;
   logic                busy_r, done_r;
   logic [7:0]          rec [NB];
   logic [7:0]          rd_r, rd_next;

   logic                en_cur;
   logic [3:0]          pi_nib;
   logic                rec_we;
   logic [31:0]         rec_word;
   logic                last_port;

   assign PO      = po_r;
   assign BUSY    = busy_r;
   assign DONE    = done_r;
   assign RD_DATA = rd_r;

   assign last_port = (idx == IW'(NPORTS-1));

   always_comb begin
      en_cur = 1'b0;
      pi_nib = 4'h0;
      for (int p = 0; p < NPORTS; p++) begin
         if (idx == IW'(p)) begin
            en_cur = PORT_EN[p];
            pi_nib = pi_s[7*p +: 4];
         end
      end
   end

   // The whole record is formed here so all four bytes land on one edge.
   // The final nibble is taken straight from the synchroniser because it
   // is captured on the same tick the record is written.
   always_comb begin
      rec_we   = 1'b0;
      rec_word = 32'hF0FF_FFFF;
      if (CE && state == S_PORT && !en_cur)
         rec_we = 1'b1;
      if (CE && state == S_SAMPLE && phase == 2'd3) begin
         rec_we = 1'b1;
         if (pi_nib[2:0] == 3'b100)
            rec_word = {8'hF1, 8'h02, nib0, nib1, nib2, pi_nib};
      end
   end

   always_comb begin
      rd_next = 8'hFF;
      for (int i = 0; i < NB; i++)
         if (RD_ADDR == AW'(i))
            rd_next = rec[i];
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         for (int i = 0; i < NB; i++)
            rec[i] <= ((i % 4) == 0) ? 8'hF0 : 8'hFF;
         rd_r <= 8'h00;
      end else begin
         rd_r <= rd_next;
         if (rec_we) begin
            for (int p = 0; p < NPORTS; p++) begin
               if (idx == IW'(p)) begin
                  rec[4*p]   <= rec_word[31:24];
                  rec[4*p+1] <= rec_word[23:16];
                  rec[4*p+2] <= rec_word[15:8];
                  rec[4*p+3] <= rec_word[7:0];
               end
            end
         end
      end
   end

   always_ff @(posedge CLK) begin
      if (RST) begin
         state   <= S_IDLE;
         pending <= 1'b0;
         idx     <= '0;
         phase   <= 2'd0;
         cnt     <= '0;
         nib0    <= 4'h0;
         nib1    <= 4'h0;
         nib2    <= 4'h0;
         pi_m    <= '0;
         pi_s    <= '0;
         po_r    <= {NPORTS{PO_IDLE}};
         busy_r  <= 1'b0;
         done_r  <= 1'b0;
      end else begin
         pi_m   <= PI;
         pi_s   <= pi_m;
         done_r <= 1'b0;
         if (state == S_IDLE && START)
            pending <= 1'b1;
         if (CE) begin
            case (state)
               S_IDLE: begin
                  if (pending) begin
                     pending <= 1'b0;
                     idx     <= '0;
                     busy_r  <= 1'b1;
                     state   <= S_PORT;
                  end
               end
               S_PORT: begin
                  if (!en_cur) begin
                     if (last_port) state <= S_FIN;
                     else begin
                        idx   <= idx + IW'(1);
                        state <= S_PORT;
                     end
                  end else begin
                     phase <= 2'd0;
                     state <= S_DRIVE;
                  end
               end
               S_DRIVE: begin
                  for (int p = 0; p < NPORTS; p++)
                     if (idx == IW'(p))
                        po_r[7*p +: 7] <= {phase, 5'b00000};
                  cnt   <= CW'(SETTLE);
                  state <= S_WAIT;
               end
               S_WAIT: begin
                  if (cnt == CW'(1)) state <= S_SAMPLE;
                  else               cnt   <= cnt - CW'(1);
               end
               S_SAMPLE: begin
                  if (phase != 2'd3) begin
                     case (phase)
                        2'd0:    nib0 <= pi_nib;
                        2'd1:    nib1 <= pi_nib;
                        default: nib2 <= pi_nib;
                     endcase
                     phase <= phase + 2'd1;
                     state <= S_DRIVE;
                  end else begin
                     for (int p = 0; p < NPORTS; p++)
                        if (idx == IW'(p))
                           po_r[7*p +: 7] <= PO_IDLE;
                     if (last_port) state <= S_FIN;
                     else begin
                        idx   <= idx + IW'(1);
                        state <= S_PORT;
                     end
                  end
               end
               S_FIN: begin
                  done_r <= 1'b1;
                  busy_r <= 1'b0;
                  state  <= S_IDLE;
               end
               default: state <= S_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_smpc_pad_scan.sv
// tb_smpc_pad_scan -- bench for smpc_pad_scan (NPORTS=2, SETTLE=2).
// A pad model answers each port's select phase with a nibble taken from
// a per-vector 16-bit word (phase 0 = top nibble). Expected record bytes
// and PO select walks are queued when a vector is driven and popped as
// the DUT produces them.

module tb_smpc_pad_scan;

   localparam int NP = 2;
   localparam int ST = 2;
   localparam int AW = $clog2(4*NP+1);

   logic            clk = 1'b0;
   logic            RST, CE, START;
   logic [NP-1:0]   PORT_EN;
   logic [7*NP-1:0] PI, PO;
   logic            BUSY, DONE;
   logic [AW-1:0]   RD_ADDR;
   logic [7:0]      RD_DATA;

   always #5 clk = ~clk;

   smpc_pad_scan #(.NPORTS(NP), .SETTLE(ST)) dut (
      .CLK(clk), .RST(RST), .CE(CE), .START(START), .PORT_EN(PORT_EN),
      .PI(PI), .PO(PO), .BUSY(BUSY), .DONE(DONE),
      .RD_ADDR(RD_ADDR), .RD_DATA(RD_DATA)
   );

   logic [15:0] nibs0 = 16'h0, nibs1 = 16'h0;

   function automatic logic [3:0] pad_nib(logic [15:0] n, logic [1:0] ph);
      case (ph)
         2'd0:    return n[15:12];
         2'd1:    return n[11:8];
         2'd2:    return n[7:4];
         default: return n[3:0];
      endcase
   endfunction

   assign PI = {3'b101, pad_nib(nibs1, PO[13:12]), 3'b011, pad_nib(nibs0, PO[6:5])};

   typedef struct {
      logic [1:0]  en;
      logic [15:0] n0, n1;
      int          ceper;
      bit          restart;
      int          lat;
      logic [31:0] e0, e1;
   } vec_t;

   vec_t vt[6];

   int nchk = 0, nerr = 0;
   int done_cnt = 0;
   int ce_per = 1, ce_ctr = 0;
   bit mon_en = 1'b0;
   logic [6:0] prev0 = 7'h60, prev1 = 7'h60;

   logic [7:0] rd_q[$];
   logic [6:0] po_q0[$], po_q1[$];

   task automatic check(string nm, logic [31:0] act, logic [31:0] exp);
      nchk++;
      if (act !== exp) begin
         nerr++;
         $display("FAIL %s: got %0h want %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(string nm, logic [31:0] act);
      nchk++;
      nerr++;
      $display("FAIL %s: got %0h want none", nm, act);
   endtask

   always @(negedge clk) begin
      if (mon_en && PO[6:0] !== prev0) begin
         if (po_q0.size() == 0) fail_now("po0_unexpected", {25'd0, PO[6:0]});
         else check("po0_walk", {25'd0, PO[6:0]}, {25'd0, po_q0.pop_front()});
      end
      if (mon_en && PO[13:7] !== prev1) begin
         if (po_q1.size() == 0) fail_now("po1_unexpected", {25'd0, PO[13:7]});
         else check("po1_walk", {25'd0, PO[13:7]}, {25'd0, po_q1.pop_front()});
      end
      prev0 = PO[6:0];
      prev1 = PO[13:7];
      if (DONE === 1'b1) done_cnt++;
   end

   task automatic cycle(output bit ce_hit);
      CE = (ce_ctr == 0);
      ce_hit = CE;
      @(posedge clk);
      #1;
      ce_ctr = (ce_ctr + 1) % ce_per;
   endtask

   task automatic push_rec(logic [31:0] w);
      rd_q.push_back(w[31:24]);
      rd_q.push_back(w[23:16]);
      rd_q.push_back(w[15:8]);
      rd_q.push_back(w[7:0]);
   endtask

   task automatic read_all();
      bit h;
      for (int a = 0; a <= 4*NP; a++) begin
         RD_ADDR = AW'(a);
         cycle(h);
         if (rd_q.size() == 0) fail_now($sformatf("rd_underflow_%0d", a), {24'd0, RD_DATA});
         else check($sformatf("rd_byte_%0d", a), {24'd0, RD_DATA}, {24'd0, rd_q.pop_front()});
      end
   endtask

   task automatic run_vec(int k);
      vec_t v;
      bit   h, got;
      int   ticks, cyc, d0;
      v = vt[k];
      PORT_EN = v.en;
      nibs0 = v.n0;
      nibs1 = v.n1;
      ce_per = v.ceper;
      ce_ctr = 0;
      if (v.en[0]) begin
         po_q0.push_back(7'h00); po_q0.push_back(7'h20);
         po_q0.push_back(7'h40); po_q0.push_back(7'h60);
      end
      if (v.en[1]) begin
         po_q1.push_back(7'h00); po_q1.push_back(7'h20);
         po_q1.push_back(7'h40); po_q1.push_back(7'h60);
      end
      push_rec(v.e0);
      push_rec(v.e1);
      rd_q.push_back(8'hFF);
      d0 = done_cnt;
      START = 1'b1;
      cycle(h);
      START = 1'b0;
      ticks = 0;
      cyc = 0;
      got = 1'b0;
      for (int i = 0; i < 1000 && !got; i++) begin
         if (v.restart && i == 20) START = 1'b1;
         cycle(h);
         START = 1'b0;
         cyc++;
         if (h) ticks++;
         if (i == 4) check($sformatf("v%0d_busy_mid", k), {31'd0, BUSY}, 32'd1);
         if (DONE === 1'b1) got = 1'b1;
      end
      if (!got) fail_now($sformatf("v%0d_done_timeout", k), ticks);
      else begin
         check($sformatf("v%0d_latency", k), ticks, v.lat);
         check($sformatf("v%0d_clk_count", k), cyc, v.lat * v.ceper);
         check($sformatf("v%0d_busy_end", k), {31'd0, BUSY}, 32'd0);
      end
      repeat (12) cycle(h);
      check($sformatf("v%0d_done_pulses", k), done_cnt - d0, 32'd1);
      check($sformatf("v%0d_busy_idle", k), {31'd0, BUSY}, 32'd0);
      check($sformatf("v%0d_po_idle", k), {18'd0, PO}, 32'h3060);
      check($sformatf("v%0d_po0_left", k), po_q0.size(), 32'd0);
      check($sformatf("v%0d_po1_left", k), po_q1.size(), 32'd0);
      ce_per = 1;
      ce_ctr = 0;
      read_all();
   endtask

   initial begin
      bit h, seen;
      int d0;
      //          en     n0        n1        ce restart lat  e0            e1
      vt[0] = '{2'b11, 16'hABC4, 16'h1234, 1, 1'b0, 36, 32'hF102ABC4, 32'hF1021234};
      vt[1] = '{2'b01, 16'h5674, 16'hABCD, 1, 1'b0, 20, 32'hF1025674, 32'hF0FFFFFF};
      vt[2] = '{2'b11, 16'hABCF, 16'h000C, 1, 1'b0, 36, 32'hF0FFFFFF, 32'hF102000C};
      vt[3] = '{2'b11, 16'hABC4, 16'h1234, 3, 1'b1, 36, 32'hF102ABC4, 32'hF1021234};
      vt[4] = '{2'b10, 16'h1234, 16'h9994, 1, 1'b0, 20, 32'hF0FFFFFF, 32'hF1029994};
      vt[5] = '{2'b00, 16'hABC4, 16'h1234, 1, 1'b0,  4, 32'hF0FFFFFF, 32'hF0FFFFFF};

      RST = 1'b1; CE = 1'b1; START = 1'b0; PORT_EN = 2'b11; RD_ADDR = '0;
      repeat (3) cycle(h);
      START = 1'b1;
      cycle(h);
      START = 1'b0;
      check("rst_busy", {31'd0, BUSY}, 32'd0);
      check("rst_done", {31'd0, DONE}, 32'd0);
      check("rst_po", {18'd0, PO}, 32'h3060);
      check("rst_rd_data", {24'd0, RD_DATA}, 32'h00);
      RST = 1'b0;
      repeat (6) cycle(h);
      check("rst_start_ignored", {31'd0, BUSY}, 32'd0);
      push_rec(32'hF0FFFFFF); push_rec(32'hF0FFFFFF); rd_q.push_back(8'hFF);
      read_all();

      mon_en = 1'b1;
      for (int k = 0; k < 6; k++) run_vec(k);

      // Reset while port 1 is settling in WAIT.
      mon_en = 1'b0;
      PORT_EN = 2'b11; nibs0 = 16'hABC4; nibs1 = 16'h1234;
      ce_per = 1; ce_ctr = 0;
      START = 1'b1;
      cycle(h);
      START = 1'b0;
      seen = 1'b0;
      for (int i = 0; i < 200 && !seen; i++) begin
         cycle(h);
         if (PO[13:7] !== 7'h60) seen = 1'b1;
      end
      if (!seen) fail_now("rst_mid_port1_timeout", {25'd0, PO[13:7]});
      cycle(h);
      d0 = done_cnt;
      RST = 1'b1;
      cycle(h);
      check("rst_mid_po", {18'd0, PO}, 32'h3060);
      check("rst_mid_busy", {31'd0, BUSY}, 32'd0);
      RST = 1'b0;
      repeat (40) cycle(h);
      check("rst_mid_no_done", done_cnt - d0, 32'd0);
      check("rst_mid_busy_after", {31'd0, BUSY}, 32'd0);
      push_rec(32'hF0FFFFFF); push_rec(32'hF0FFFFFF); rd_q.push_back(8'hFF);
      read_all();

      mon_en = 1'b1;
      run_vec(0);

      $display("Result: errors=%0d of %0d checks", nerr, nchk);
      $finish;
   end

endmodule
